// File: rtl/traffic_phase_sched.sv
// Two-road intersection phase scheduler: sequences green/yellow/all-red lamp groups,
// supports demand gap-out and emergency all-red hold, and drives a BCD countdown.
module traffic_phase_sched #(
    parameter int unsigned GREEN1_S    = 30,
    parameter int unsigned GREEN2_S    = 20,
    parameter int unsigned YELLOW_S    = 3,
    parameter int unsigned ALLRED_S    = 1,
    parameter int unsigned MIN_GREEN_S = 5
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_tick,
    input  logic       i_req1,
    input  logic       i_req2,
    input  logic       i_emerg,
    output logic       o_red1,
    output logic       o_yellow1,
    output logic       o_green1,
    output logic       o_red2,
    output logic       o_yellow2,
    output logic       o_green2,
    output logic [2:0] o_phase,
    output logic [6:0] o_remain,
    output logic [3:0] o_rem_tens,
    output logic [3:0] o_rem_ones
);

    localparam logic [2:0] ST_G1  = 3'd0;
    localparam logic [2:0] ST_Y1  = 3'd1;
    localparam logic [2:0] ST_AR1 = 3'd2;
    localparam logic [2:0] ST_G2  = 3'd3;
    localparam logic [2:0] ST_Y2  = 3'd4;
    localparam logic [2:0] ST_AR2 = 3'd5;
    localparam logic [2:0] ST_EMG = 3'd6;

    localparam logic [6:0] D_G1 = 7'(GREEN1_S);
    localparam logic [6:0] D_G2 = 7'(GREEN2_S);
    localparam logic [6:0] D_Y  = 7'(YELLOW_S);
    localparam logic [6:0] D_AR = 7'(ALLRED_S);

    // Lamp vector order: {red1, yellow1, green1, red2, yellow2, green2}
    localparam logic [5:0] LAMPS_RESET = 6'b001_100;

    function automatic logic [3:0] bcd_tens(input logic [6:0] v);
        return 4'(v / 7'd10);
    endfunction

    function automatic logic [3:0] bcd_ones(input logic [6:0] v);
        return 4'(v % 7'd10);
    endfunction

    logic [2:0] r_state;
    logic [6:0] r_remain;
    logic [5:0] r_lamps;
    logic [3:0] r_tens;
    logic [3:0] r_ones;

    logic [2:0] w_state_nxt;
    logic [6:0] w_remain_nxt;
    logic [5:0] w_lamps_nxt;
    logic       w_last;
    logic       w_gap1;
    logic       w_gap2;

    // Elapsed-green test rewritten as remain + MIN <= GREEN + 1 to avoid underflow.
    assign w_last = (r_remain <= 7'd1);
    assign w_gap1 = i_req2 & ~i_req1 &
                    (({1'b0, r_remain} + 8'(MIN_GREEN_S)) <= (8'(GREEN1_S) + 8'd1));
    assign w_gap2 = i_req1 & ~i_req2 &
                    (({1'b0, r_remain} + 8'(MIN_GREEN_S)) <= (8'(GREEN2_S) + 8'd1));

    // State, countdown and all registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= ST_G1;
            r_remain <= D_G1;
            r_lamps  <= LAMPS_RESET;
            r_tens   <= bcd_tens(D_G1);
            r_ones   <= bcd_ones(D_G1);
        end else begin
            r_state  <= w_state_nxt;
            r_remain <= w_remain_nxt;
            r_lamps  <= w_lamps_nxt;
            r_tens   <= bcd_tens(w_remain_nxt);
            r_ones   <= bcd_ones(w_remain_nxt);
        end
    end

    // Next phase and countdown; emergency in green preempts tick handling.
    always_comb begin
        w_state_nxt  = r_state;
        w_remain_nxt = r_remain;
        case (r_state)
            ST_G1: begin
                if (i_emerg) begin
                    w_state_nxt  = ST_Y1;
                    w_remain_nxt = D_Y;
                end else if (i_tick && (w_last || w_gap1)) begin
                    w_state_nxt  = ST_Y1;
                    w_remain_nxt = D_Y;
                end else if (i_tick) begin
                    w_remain_nxt = r_remain - 7'd1;
                end else begin
                    w_remain_nxt = r_remain;
                end
            end
            ST_Y1: begin
                if (i_tick && w_last) begin
                    w_state_nxt  = ST_AR1;
                    w_remain_nxt = D_AR;
                end else if (i_tick) begin
                    w_remain_nxt = r_remain - 7'd1;
                end else begin
                    w_remain_nxt = r_remain;
                end
            end
            ST_AR1: begin
                if (i_tick && w_last && i_emerg) begin
                    w_state_nxt  = ST_EMG;
                    w_remain_nxt = 7'd0;
                end else if (i_tick && w_last) begin
                    w_state_nxt  = ST_G2;
                    w_remain_nxt = D_G2;
                end else if (i_tick) begin
                    w_remain_nxt = r_remain - 7'd1;
                end else begin
                    w_remain_nxt = r_remain;
                end
            end
            ST_G2: begin
                if (i_emerg) begin
                    w_state_nxt  = ST_Y2;
                    w_remain_nxt = D_Y;
                end else if (i_tick && (w_last || w_gap2)) begin
                    w_state_nxt  = ST_Y2;
                    w_remain_nxt = D_Y;
                end else if (i_tick) begin
                    w_remain_nxt = r_remain - 7'd1;
                end else begin
                    w_remain_nxt = r_remain;
                end
            end
            ST_Y2: begin
                if (i_tick && w_last) begin
                    w_state_nxt  = ST_AR2;
                    w_remain_nxt = D_AR;
                end else if (i_tick) begin
                    w_remain_nxt = r_remain - 7'd1;
                end else begin
                    w_remain_nxt = r_remain;
                end
            end
            ST_AR2: begin
                if (i_tick && w_last && i_emerg) begin
                    w_state_nxt  = ST_EMG;
                    w_remain_nxt = 7'd0;
                end else if (i_tick && w_last) begin
                    w_state_nxt  = ST_G1;
                    w_remain_nxt = D_G1;
                end else if (i_tick) begin
                    w_remain_nxt = r_remain - 7'd1;
                end else begin
                    w_remain_nxt = r_remain;
                end
            end
            ST_EMG: begin
                if (i_tick && !i_emerg) begin
                    w_state_nxt  = ST_G1;
                    w_remain_nxt = D_G1;
                end else begin
                    w_remain_nxt = 7'd0;
                end
            end
            default: begin
                w_state_nxt  = ST_G1;
                w_remain_nxt = D_G1;
            end
        endcase
    end

    // Lamp decode of the upcoming state so lamps register alongside the phase.
    always_comb begin
        w_lamps_nxt = 6'b100_100;
        case (w_state_nxt)
            ST_G1:   w_lamps_nxt = 6'b001_100;
            ST_Y1:   w_lamps_nxt = 6'b010_100;
            ST_G2:   w_lamps_nxt = 6'b100_001;
            ST_Y2:   w_lamps_nxt = 6'b100_010;
            default: w_lamps_nxt = 6'b100_100;
        endcase
    end

    assign o_red1     = r_lamps[5];
    assign o_yellow1  = r_lamps[4];
    assign o_green1   = r_lamps[3];
    assign o_red2     = r_lamps[2];
    assign o_yellow2  = r_lamps[1];
    assign o_green2   = r_lamps[0];
    assign o_phase    = r_state;
    assign o_remain   = r_remain;
    assign o_rem_tens = r_tens;
    assign o_rem_ones = r_ones;

endmodule

// Lamp-safety checker: one lamp per road, never yellow on one road while the other is green.
module traffic_phase_sched_chk (
    input logic i_clk,
    input logic i_reset,
    input logic i_red1,
    input logic i_yellow1,
    input logic i_green1,
    input logic i_red2,
    input logic i_yellow2,
    input logic i_green2
);

    a_lamp_excl: assert property (@(posedge i_clk) disable iff (i_reset)
        ($onehot({i_red1, i_yellow1, i_green1}) &&
         $onehot({i_red2, i_yellow2, i_green2}) &&
         !(i_yellow1 && i_green2) && !(i_yellow2 && i_green1)))
        else $error("lamp exclusivity violated");

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Bench for traffic_phase_sched: vector table, directed corner sequences and
// randomized traffic against a phase-table reference model.
module tb_traffic_phase_sched;

    logic       clk = 1'b0;
    logic       reset, tick, req1, req2, emerg;
    logic       red1, yellow1, green1, red2, yellow2, green2;
    logic [2:0] phase;
    logic [6:0] remain;
    logic [3:0] rem_tens, rem_ones;

    always #5 clk = ~clk;

    traffic_phase_sched dut (
        .i_clk(clk), .i_reset(reset), .i_tick(tick),
        .i_req1(req1), .i_req2(req2), .i_emerg(emerg),
        .o_red1(red1), .o_yellow1(yellow1), .o_green1(green1),
        .o_red2(red2), .o_yellow2(yellow2), .o_green2(green2),
        .o_phase(phase), .o_remain(remain),
        .o_rem_tens(rem_tens), .o_rem_ones(rem_ones)
    );

    traffic_phase_sched_chk chk (
        .i_clk(clk), .i_reset(reset),
        .i_red1(red1), .i_yellow1(yellow1), .i_green1(green1),
        .i_red2(red2), .i_yellow2(yellow2), .i_green2(green2)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: phase index 0..5 around the ring, 6 = emergency hold.
    int m_phase = 0;
    int m_rem   = 30;
    int dur [6] = '{30, 3, 1, 20, 3, 1};

    function automatic int lamps_of(input int p);
        case (p)
            0:       return 32'b001_100;
            1:       return 32'b010_100;
            3:       return 32'b100_001;
            4:       return 32'b100_010;
            default: return 32'b100_100;
        endcase
    endfunction

    function automatic int model_vec();
        return (m_phase << 21) | (m_rem << 14) | ((m_rem / 10) << 10) |
               ((m_rem % 10) << 6) | lamps_of(m_phase);
    endfunction

    function automatic int dut_vec();
        return int'({phase, remain, rem_tens, rem_ones,
                     red1, yellow1, green1, red2, yellow2, green2});
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic model_step(input logic rs, tk, r1, r2, em);
        bit green;
        int elapsed;
        green   = (m_phase == 0) || (m_phase == 3);
        elapsed = ((m_phase == 0) ? 30 : 20) - m_rem + 1;
        if (rs) begin
            m_phase = 0; m_rem = 30;
        end else if (m_phase == 6) begin
            if (tk && !em) begin m_phase = 0; m_rem = 30; end
        end else if (green && em) begin
            m_phase = m_phase + 1; m_rem = 3;
        end else if (tk) begin
            if (m_rem == 1) begin
                if (((m_phase == 2) || (m_phase == 5)) && em) begin
                    m_phase = 6; m_rem = 0;
                end else begin
                    m_phase = (m_phase + 1) % 6; m_rem = dur[m_phase];
                end
            end else if (green && elapsed >= 5 &&
                         ((m_phase == 0) ? (r2 && !r1) : (r1 && !r2))) begin
                m_phase = m_phase + 1; m_rem = 3;
            end else begin
                m_rem = m_rem - 1;
            end
        end
    endtask

    task automatic drive(input logic rs, tk, r1, r2, em);
        reset = rs; tick = tk; req1 = r1; req2 = r2; emerg = em;
        model_step(rs, tk, r1, r2, em);
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic rs, tk, r1, r2, em, input string name);
        drive(rs, tk, r1, r2, em);
        check(name, dut_vec(), model_vec());
    endtask

    // One tick followed by idle cycles, so ticks stay one clock wide.
    task automatic tick_n(input int n, input logic r1, r2, em, input string name);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b1, r1, r2, em, name);
            cyc(1'b0, 1'b0, r1, r2, em, name);
        end
    endtask

    typedef struct {
        logic rs, tk, r1, r2, em;
        int   ph, rem;
    } vec_t;

    vec_t vecs [19];
    int   durs [$];

    initial begin
        reset = 1'b1; tick = 1'b0; req1 = 1'b0; req2 = 1'b0; emerg = 1'b0;
        @(posedge clk);
        #1;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 30};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 29};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 29};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 29};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 28};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 27};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 26};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 3};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1, 2};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2, 1};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6, 0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6, 0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 30};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 3};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0, 30};
        vecs[16] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 29};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 28};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 27};

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].rs, vecs[i].tk, vecs[i].r1, vecs[i].r2, vecs[i].em);
            check($sformatf("vec%0d phase", i), int'(phase), vecs[i].ph);
            check($sformatf("vec%0d remain", i), int'(remain), vecs[i].rem);
            check($sformatf("vec%0d bcd", i), int'({rem_tens, rem_ones}),
                  ((vecs[i].rem / 10) << 4) | (vecs[i].rem % 10));
            check($sformatf("vec%0d lamps", i),
                  int'({red1, yellow1, green1, red2, yellow2, green2}),
                  lamps_of(vecs[i].ph));
        end

        // Free-running cycle with a tick every 10 clocks: measure phase lengths.
        begin
            int cnt;
            logic [2:0] prev;
            cnt = 0;
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "cycle reset");
            check("reset bcd", int'({rem_tens, rem_ones}), 32'h30);
            for (int k = 0; k < 600; k++) begin
                logic t;
                t    = ((k % 10) == 9);
                prev = phase;
                cyc(1'b0, t, 1'b0, 1'b0, 1'b0, "cycle");
                if (t) cnt++;
                if (phase != prev) begin
                    durs.push_back(cnt);
                    cnt = 0;
                    if (phase == 3'd3) check("G2 entry bcd", int'({rem_tens, rem_ones}), 32'h20);
                    if (phase == 3'd0) check("G1 entry bcd", int'({rem_tens, rem_ones}), 32'h30);
                end
            end
            check("phase change count", durs.size(), 6);
            if (durs.size() >= 6) begin
                for (int i = 0; i < 6; i++)
                    check($sformatf("duration of phase %0d", i), durs[i], dur[i]);
            end
        end

        // Emergency in G1 at Remain=12 without a tick, then normal continuation to G2.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "emg reset");
        tick_n(18, 1'b0, 1'b0, 1'b0, "emg approach");
        check("emg pre remain", int'(remain), 12);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "emg pulse");
        check("emg jump phase", int'(phase), 1);
        check("emg jump remain", int'(remain), 3);
        tick_n(3, 1'b0, 1'b0, 1'b0, "emg yellow");
        check("emg AR1 phase", int'(phase), 2);
        check("emg AR1 remain", int'(remain), 1);
        tick_n(1, 1'b0, 1'b0, 1'b0, "emg AR1");
        check("emg then G2", int'(phase), 3);
        check("emg G2 remain", int'(remain), 20);

        // Emergency held through Y2 and AR2 into EMG, held 10 ticks, then release.
        tick_n(20, 1'b0, 1'b0, 1'b0, "to Y2");
        check("Y2 reached", int'(phase), 4);
        tick_n(4, 1'b0, 1'b0, 1'b1, "Y2/AR2 with emerg");
        check("EMG phase", int'(phase), 6);
        check("EMG lamps", int'({red1, yellow1, green1, red2, yellow2, green2}), 32'b100_100);
        tick_n(10, 1'b0, 1'b0, 1'b1, "EMG hold");
        check("EMG held", int'({phase, remain}), 6 << 7);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "EMG release no tick");
        check("EMG waits for tick", int'(phase), 6);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "EMG exit");
        check("EMG exit remain", int'({phase, remain}), 30);

        // Reset in G2 at Remain=7.
        tick_n(47, 1'b0, 1'b0, 1'b0, "to G2 rem7");
        check("G2 rem7", int'({phase, remain}), (3 << 7) | 7);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "reset in G2");
        check("reset in G2 lamps", int'({red1, yellow1, green1, red2, yellow2, green2}),
              32'b001_100);
        check("reset in G2 remain", int'({phase, remain}), 30);

        // Randomized traffic, including held ticks and occasional resets.
        begin
            logic r1, r2, em;
            r1 = 1'b0; r2 = 1'b0; em = 1'b0;
            for (int k = 0; k < 3000; k++) begin
                if ($urandom_range(0, 7) == 0) r1 = ~r1;
                if ($urandom_range(0, 7) == 0) r2 = ~r2;
                if ($urandom_range(0, 39) == 0) em = ~em;
                cyc(($urandom_range(0, 399) == 0), ($urandom_range(0, 3) == 0),
                    r1, r2, em, "random");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
